seq_detect_param: RTL and testbench
===================================

Name: seq_detect_param

Overview:
- Parameterised serial bit-pattern detector, successor to the fixed 4-bit "1110" FSM detector.
- Pattern and length are runtime-programmable up to PAT_W bits. Overlapping and non-overlapping modes are supported, and input bits carry a valid qualifier.
- Sits on a 1-bit serial stream (line decoder / frame-sync front end). Output is Mealy: it flags the cycle the final pattern bit arrives.

Parameters:
- PAT_W, 8, maximum pattern length in bits (>=2)
- DEF_PAT, 8'b0000_1110, pattern loaded at reset (LSB-aligned)
- DEF_LEN, 4, pattern length loaded at reset (1..PAT_W)
- CNT_W, 16, match counter width (optional feature only)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- ip  input  1  serial data bit
- ip_valid  input  1  ip is sampled only when 1
- cfg_load  input  1  one-cycle pulse; latch cfg_pattern/cfg_len/cfg_overlap
- cfg_pattern  input  PAT_W  new pattern; bit[len-1] is the first bit received, bit[0] the last
- cfg_len  input  $clog2(PAT_W+1)  new pattern length
- cfg_overlap  input  1  1 = overlapping matches allowed
- seq_detect  output  1  combinational Mealy match flag
- match_cnt  output  CNT_W  saturating match count (present only with the macro)

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - pattern=DEF_PAT, len=DEF_LEN, overlap=1
  - hist=0, fill=0
  - match_cnt=0
  - seq_detect is driven 0 while in reset.
- State registers:
  - hist[PAT_W-1:0]: shift register of past bits.
  - fill: count of valid bits held, saturating at PAT_W.
- Match (combinational, same cycle as the last bit): seq_detect = ip_valid && len!=0 && fill>=len-1 && {hist[len-2:0],ip}==pattern[len-1:0].
  - For len==1 this reduces to ip_valid && ip==pattern[0].
- On a clock edge with ip_valid=1:
  - hist <= {hist[PAT_W-2:0], ip}.
  - fill <= sat(fill+1).
  - If seq_detect=1 and overlap=0, fill <= 0 instead. The history still shifts, but the matched bits cannot be reused.
- ip_valid=0: hist and fill hold, seq_detect=0. Bubbles do not break a sequence.
- cfg_load=1:
  - Next edge latches the config and clears hist and fill.
  - cfg_load has priority over ip_valid; the bit presented in that cycle is discarded.
  - seq_detect in the cfg_load cycle still reflects the old config.
- Length rules:
  - cfg_len==0 disables detection (seq_detect stays 0).
  - cfg_len>PAT_W is clamped to PAT_W at latch time.
- Latency:
  - Detect: 0 cycles after the final bit is presented (Mealy).
  - Counter: updates on the edge that ends the detect cycle.
- Equivalence: with DEF_PAT/DEF_LEN and overlap=1, behaviour is identical to the legacy 1110 detector. The one difference is the legacy restart quirk, which is intentionally dropped in favour of a correct sliding-window match.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined:
  - match_cnt port exists.
  - Increments on each edge where seq_detect=1, saturating at 2^CNT_W-1.
  - Clears on reset and on cfg_load.
- Undefined: the port and counter are absent; all other behaviour is unchanged.

Decomposition:
- Shared package seq_detect_pkg holds:
  - PAT_W and DEF_PAT/DEF_LEN defaults
  - function clamp_len()
  - function pat_mask(len), returning the low-len-bits mask used for comparison
- One natural sub-module: seq_match_cnt, the saturating counter with clear. It is instantiated only under the macro.

Test Plan:
- Reset then defaults, ip=0,1,1,1,0 with valid each cycle → seq_detect=1 only in the 5th cycle (ip=0); match_cnt=1 afterwards.
- Overlap: load pattern 3'b101, len 3, overlap=1; feed 1,0,1,0,1 → seq_detect=1 at bits 3 and 5. Repeat with overlap=0 → 1 at bit 3 only.
- Bubbles: default pattern fed 1,(valid=0 for 3 cycles),1,1,0 → detect on the final 0. Repeat the stream with ip=0 but ip_valid=0 inside the gap → no false detect.
- Config edge cases:
  - cfg_len=0 → no detect on any stream.
  - cfg_len=12 with PAT_W=8 → behaves as len 8.
  - cfg_load mid-sequence (after 1,1,1) then 0 → no detect.
- Reset mid-operation: drop rst to 0 asynchronously between edges after 1,1,1 → seq_detect=0 immediately, match_cnt=0. After release, the stream 0 yields no detect.
- Saturation (CNT_W=2, macro on): 5 consecutive matches of len-1 pattern 1'b1 → match_cnt sticks at 3.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared defaults and pattern-length helpers for seq_detect_param
package seq_detect_pkg;

  localparam int                   SD_PAT_W   = 8;
  localparam logic [SD_PAT_W-1:0]  SD_DEF_PAT = 8'b0000_1110;
  localparam int                   SD_DEF_LEN = 4;
  localparam int                   SD_CNT_W   = 16;
  // Widest mask the helper can build; PAT_W must not exceed this.
  localparam int                   SD_MASK_W  = 64;

  function automatic int clamp_len(input int len, input int max_len);
    if (len > max_len) return max_len;
    if (len < 0) return 0;
    return len;
  endfunction

  function automatic logic [SD_MASK_W-1:0] pat_mask(input int len);
    logic [SD_MASK_W-1:0] m;
    m = '0;
    for (int i = 0; i < SD_MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// rtl/seq_match_cnt.sv - saturating match counter with synchronous clear
module seq_match_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - programmable serial pattern detector, Mealy match flag
// Optional match counter port enabled by SEQ_DETECT_MATCH_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = SD_PAT_W,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(SD_DEF_PAT),
  parameter int               DEF_LEN = SD_DEF_LEN,
  parameter int               CNT_W   = SD_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ip,
  input  logic                       ip_valid,
  input  logic                       cfg_load,
  input  logic [PAT_W-1:0]           cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0] cfg_len,
  input  logic                       cfg_overlap,
`ifdef SEQ_DETECT_MATCH_CNT_EN
  output logic [CNT_W-1:0]           match_cnt,
`endif
  output logic                       seq_detect
);

  localparam int LEN_W = $clog2(PAT_W+1);

  logic [PAT_W-1:0] pattern_q;
  logic [PAT_W-1:0] hist_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] fill_q;
  logic             overlap_q;

  logic [PAT_W-1:0] mask;
  logic [PAT_W-1:0] window;
  logic [LEN_W:0]   fill_next_ext;
  logic             match_hit;

  // window is the history as it would look once ip is shifted in; the
  // newest bit sits at [0], matching pattern bit order.
  always_comb begin
    mask          = PAT_W'(pat_mask(int'(len_q)));
    window        = {hist_q[PAT_W-2:0], ip};
    fill_next_ext = {1'b0, fill_q} + (LEN_W+1)'(1);
    match_hit     = (len_q != '0) &&
                    (fill_next_ext >= {1'b0, len_q}) &&
                    ((window & mask) == (pattern_q & mask));
    seq_detect    = rst && ip_valid && match_hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_q <= DEF_PAT;
      len_q     <= LEN_W'(clamp_len(DEF_LEN, PAT_W));
      overlap_q <= 1'b1;
      hist_q    <= '0;
      fill_q    <= '0;
    end else if (cfg_load) begin
      pattern_q <= cfg_pattern;
      len_q     <= LEN_W'(clamp_len(int'(cfg_len), PAT_W));
      overlap_q <= cfg_overlap;
      hist_q    <= '0;
      fill_q    <= '0;
    end else if (ip_valid) begin
      hist_q <= window;
      // Non-overlapping mode: bits of a completed match may not start another.
      if (seq_detect && !overlap_q) begin
        fill_q <= '0;
      end else if (fill_q != LEN_W'(PAT_W)) begin
        fill_q <= fill_q + LEN_W'(1);
      end
    end
  end

  logic unused_hist_msb;
  assign unused_hist_msb = hist_q[PAT_W-1];

`ifdef SEQ_DETECT_MATCH_CNT_EN
  seq_match_cnt #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load),
    .inc (seq_detect),
    .cnt (match_cnt)
  );
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - randomized self-checking bench for seq_detect_param
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = $clog2(PAT_W+1);
  localparam int CNT_W = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             ip = 1'b0;
  logic             ip_valid = 1'b0;
  logic             cfg_load = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic             cfg_overlap = 1'b0;
  logic             seq_detect;
`ifdef SEQ_DETECT_MATCH_CNT_EN
  logic [CNT_W-1:0] match_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the list of bits still usable for a match, newest last.
  logic [PAT_W-1:0] m_pat;
  int               m_len;
  logic             m_ov;
  logic             m_bits[$];
  int               m_cnt;

  always #5 clk = ~clk;

  seq_detect_param #(
    .PAT_W   (PAT_W),
    .DEF_PAT (8'b0000_1110),
    .DEF_LEN (4),
    .CNT_W   (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ip          (ip),
    .ip_valid    (ip_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
`ifdef SEQ_DETECT_MATCH_CNT_EN
    .match_cnt   (match_cnt),
`endif
    .seq_detect  (seq_detect)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pat = 8'b0000_1110;
    m_len = 4;
    m_ov  = 1'b1;
    m_bits.delete();
    m_cnt = 0;
  endfunction

  function automatic logic model_det(input logic v, input logic b);
    int   n;
    logic bk;
    if (!v || m_len == 0) return 1'b0;
    n = m_bits.size();
    if (n < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      bk = (k == m_len - 1) ? b : m_bits[n - (m_len - 1) + k];
      if (bk != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check_cnt(input string tag);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    check(tag, 32'(match_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock: present inputs mid-cycle, check the Mealy output, then advance the model.
  task automatic apply(input logic v, input logic b, input logic ld,
                       input logic [PAT_W-1:0] pat, input int len, input logic ov);
    logic det;
    @(negedge clk);
    ip = b; ip_valid = v; cfg_load = ld;
    cfg_pattern = pat; cfg_len = LEN_W'(len); cfg_overlap = ov;
    #1;
    det = model_det(v, b);
    check(ld ? "detect_load" : "detect", 32'(seq_detect), 32'(det));
    check_cnt("cnt");
    @(posedge clk);
    if (ld) begin
      m_pat = pat;
      m_len = (len > PAT_W) ? PAT_W : len;
      m_ov  = ov;
      m_bits.delete();
      m_cnt = 0;
    end else if (v) begin
      if (det && m_cnt < CNT_MAX) m_cnt++;
      m_bits.push_back(b);
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (det && !m_ov) m_bits.delete();
    end
  endtask

  task automatic bit_in(input logic b);
    apply(1'b1, b, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic bubble(input logic b);
    apply(1'b0, b, 1'b0, '0, 0, 1'b0);
  endtask

  task automatic load(input logic [PAT_W-1:0] pat, input int len, input logic ov);
    apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, pat, len, ov);
  endtask

  initial begin
    model_reset();
    ip_valid = 1'b1; ip = 1'b0;
    #12;
    check("detect_in_reset", 32'(seq_detect), 32'd0);
    check_cnt("cnt_reset");
    @(negedge clk);
    ip_valid = 1'b0;
    rst = 1'b1;

    // Default 1110 pattern
    bit_in(0); bit_in(1); bit_in(1); bit_in(1); bit_in(0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    @(negedge clk); #1;
    check("cnt_default", 32'(match_cnt), 32'd1);
`endif

    // Overlapping then non-overlapping 101
    load(8'b101, 3, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    load(8'b101, 3, 1'b0);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);

    // Bubbles inside a sequence
    load(8'b0000_1110, 4, 1'b1);
    bit_in(1); bubble(1); bubble(0); bubble(1); bit_in(1); bit_in(1); bit_in(0);
    bit_in(1); bubble(0); bubble(0); bubble(0); bit_in(1); bit_in(0);

    // Length 0 disables, length 12 clamps to 8
    load(8'b0000_0001, 0, 1'b1);
    for (int i = 0; i < 12; i++) bit_in(1'($urandom_range(0, 1)));
    load(8'b1010_0101, 12, 1'b1);
    for (int i = PAT_W - 1; i >= 0; i--) bit_in(1'((8'b1010_0101 >> i) & 1));
    for (int i = PAT_W - 1; i >= 0; i--) bit_in(1'((8'b1010_0101 >> i) & 1));

    // Reload mid-sequence discards history
    load(8'b0000_1110, 4, 1'b1);
    bit_in(1); bit_in(1); bit_in(1);
    load(8'b0000_1110, 4, 1'b1);
    bit_in(0);

    // Asynchronous reset between edges
    bit_in(1); bit_in(1); bit_in(1);
    @(negedge clk);
    ip = 1'b0; ip_valid = 1'b1; cfg_load = 1'b0;
    #1;
    check("detect_pre_reset", 32'(seq_detect), 32'(model_det(1'b1, 1'b0)));
    #1 rst = 1'b0;
    #1;
    check("detect_async_reset", 32'(seq_detect), 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    check("cnt_async_reset", 32'(match_cnt), 32'd0);
`endif
    model_reset();
    ip_valid = 1'b0;
    #1 rst = 1'b1;
    bit_in(0);

    // Counter saturation with a 1-bit pattern
    load(8'b1, 1, 1'b1);
    for (int i = 0; i < 5; i++) bit_in(1);
`ifdef SEQ_DETECT_MATCH_CNT_EN
    @(negedge clk); #1;
    check("cnt_saturate", 32'(match_cnt), 32'(CNT_MAX));
`endif

    // Random traffic with occasional reconfiguration
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        load(PAT_W'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                           : int'($urandom_range(1, 4)),
             1'($urandom_range(0, 1)));
      end else begin
        apply(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, '0, 0, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
